// File: rtl/eth_tlptap_arb.sv
// rtl/eth_tlptap_arb.sv - packet-granular round-robin drain of two FWFT tap FIFOs onto one 64-bit TLP AXI-Stream
module eth_tlptap_arb #(
  parameter int C_DATA_WIDTH = 64,
  parameter int ENTRY_WIDTH  = 81,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  output logic                    rd_en0,
  output logic                    rd_en1,
  input  logic [ENTRY_WIDTH-1:0]  dout0,
  input  logic [ENTRY_WIDTH-1:0]  dout1,
  input  logic                    empty0,
  input  logic                    empty1,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [7:0]              m_axis_tkeep,
  output logic [7:0]              m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
`ifdef TLPTAP_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]    pkt_cnt0,
  output logic [CNT_WIDTH-1:0]    pkt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, XFER0, XFER1} state_t;

  state_t                 state_q, state_d;
  logic                   rr_last_q;
  logic [ENTRY_WIDTH-1:0] head;
  logic                   src_empty;
  logic                   load;
  logic                   pop_last;

  always_comb begin
    state_d   = state_q;
    head      = dout0;
    src_empty = 1'b1;
    case (state_q)
      XFER0: begin
        head      = dout0;
        src_empty = empty0;
      end
      XFER1: begin
        head      = dout1;
        src_empty = empty1;
      end
      default: begin
        if (!empty0 && (empty1 || rr_last_q))
          state_d = XFER0;
        else if (!empty1)
          state_d = XFER1;
      end
    endcase
    load     = !src_empty && (!m_axis_tvalid || m_axis_tready);
    rd_en0   = load && (state_q == XFER0);
    rd_en1   = load && (state_q == XFER1);
    pop_last = load && head[0];
    if (pop_last)
      state_d = IDLE;
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q       <= IDLE;
      rr_last_q     <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop_last)
        rr_last_q <= (state_q == XFER1);
      if (load) begin
        m_axis_tdata  <= head[C_DATA_WIDTH+8:9];
        m_axis_tkeep  <= head[C_DATA_WIDTH+16:C_DATA_WIDTH+9];
        m_axis_tuser  <= head[8:1];
        m_axis_tlast  <= head[0];
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef TLPTAP_ARB_STATS_EN
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (pop_last) begin
      if (state_q == XFER1)
        pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
      else
        pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_eth_tlptap_arb.sv
// tb/tb_eth_tlptap_arb.sv - self-checking bench for eth_tlptap_arb
module tb_eth_tlptap_arb;

  logic        clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        rd_en0, rd_en1;
  logic [80:0] dout0, dout1;
  logic        empty0, empty1;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep, m_axis_tuser;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
`ifdef TLPTAP_ARB_STATS_EN
  logic [1:0]  pkt_cnt0, pkt_cnt1;
`endif

  always #5 clk = ~clk;

  eth_tlptap_arb #(.CNT_WIDTH(2)) dut (
    .user_clk(clk), .user_reset(user_reset),
    .rd_en0(rd_en0), .rd_en1(rd_en1),
    .dout0(dout0), .dout1(dout1), .empty0(empty0), .empty1(empty1),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
`ifdef TLPTAP_ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  logic [80:0] mem0 [0:1023];
  logic [80:0] mem1 [0:1023];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

  assign empty0 = (rd0 == wr0);
  assign empty1 = (rd1 == wr1);
  assign dout0  = empty0 ? '0 : mem0[rd0[9:0]];
  assign dout1  = empty1 ? '0 : mem1[rd1[9:0]];

  always @(posedge clk) begin
    if (rd_en0 && rd0 < wr0) rd0 <= rd0 + 1;
    if (rd_en1 && rd1 < wr1) rd1 <= rd1 + 1;
  end

  wire [80:0] out_ent = {m_axis_tkeep, m_axis_tdata, m_axis_tuser, m_axis_tlast};

  typedef struct packed {
    logic        rdy;
    logic        valid;
    logic [80:0] ent;
    logic        rd0;
    logic        rd1;
  } vec_t;

  vec_t        tbl[$];
  logic [80:0] got[$];
  logic [80:0] exp_q[$];
  logic [80:0] s0q[$];
  logic [80:0] s1q[$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_q = 1'b0;
  logic [80:0] stall_ent = '0;

  function automatic logic [80:0] mk(input int s, input int p, input int b, input bit last,
                                     input logic [7:0] keep);
    logic [63:0] d;
    d = {4'hD, s[3:0], p[7:0], b[7:0], 40'h0123456789};
    return {keep, d, s[3:0], b[3:0], last};
  endfunction

  function automatic vec_t row(input logic rdy, input logic valid, input logic [80:0] ent,
                               input logic r0, input logic r1);
    vec_t v;
    v.rdy = rdy; v.valid = valid; v.ent = ent; v.rd0 = r0; v.rd1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push0(input logic [80:0] e);
    mem0[wr0[9:0]] = e;
    wr0++;
  endtask

  task automatic push1(input logic [80:0] e);
    mem1[wr1[9:0]] = e;
    wr1++;
  endtask

  task automatic tick(input logic rdy);
    @(negedge clk);
    m_axis_tready = rdy;
    #1;
    if (user_reset) begin
      stall_q = 1'b0;
    end else begin
      chk("rd_en_exclusive", rd_en0 & rd_en1, 0);
      chk("rd_en_when_empty", (rd_en0 & empty0) | (rd_en1 & empty1), 0);
      if (stall_q) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_data", out_ent, stall_ent);
      end
      stall_q   = m_axis_tvalid && !rdy;
      stall_ent = out_ent;
      if (m_axis_tvalid && rdy) got.push_back(out_ent);
    end
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    tick(1);
    tick(1);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_fields", out_ent, 0);
    chk("reset_rd_en", {rd_en1, rd_en0}, 0);
`ifdef TLPTAP_ARB_STATS_EN
    chk("reset_pkt_cnt", {pkt_cnt1, pkt_cnt0}, 0);
`endif
  endtask

  task automatic run_rows(input int lo, input int hi, input string name);
    for (int i = lo; i < hi; i++) begin
      tick(tbl[i].rdy);
      chk($sformatf("%s[%0d].tvalid", name, i - lo), m_axis_tvalid, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("%s[%0d].beat", name, i - lo), out_ent, tbl[i].ent);
      chk($sformatf("%s[%0d].rd_en0", name, i - lo), rd_en0, tbl[i].rd0);
      chk($sformatf("%s[%0d].rd_en1", name, i - lo), rd_en1, tbl[i].rd1);
    end
  endtask

  task automatic cmp_got(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic drain(input int n, input int budget, input bit rand_rdy);
    for (int c = 0; c < budget && got.size() < n; c++)
      tick(rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  initial begin
    int t1_lo, t2_lo, t4_lo, t_end;
    logic [80:0] a[3], p0[4], p1[4], q0[4], q1[4], c[4], d[4], f[4], g[2], e0;
    bit saw_rd1;

    for (int b = 0; b < 3; b++) a[b] = mk(0, 1, b, b == 2, b == 2 ? 8'h0F : 8'hFF);
    for (int b = 0; b < 2; b++) begin
      p0[b] = mk(0, 2, b, b == 1, 8'hFF);
      p1[b] = mk(0, 3, b, b == 1, 8'hFF);
      q0[b] = mk(1, 2, b, b == 1, 8'hFF);
      q1[b] = mk(1, 3, b, b == 1, 8'hFF);
    end
    for (int b = 0; b < 4; b++) begin
      c[b] = mk(0, 4, b, b == 3, 8'hFF);
      d[b] = mk(0, 5, b, b == 3, 8'h3F);
      f[b] = mk(0, 6, b, b == 3, 8'h07);
    end
    g[0] = mk(1, 6, 0, 0, 8'hFF);
    g[1] = mk(1, 6, 1, 1, 8'h01);
    e0   = mk(1, 5, 0, 1, 8'hFF);

    t1_lo = tbl.size();
    tbl.push_back(row(1, 0, '0,   1, 0));
    tbl.push_back(row(1, 1, a[0], 1, 0));
    tbl.push_back(row(1, 1, a[1], 1, 0));
    tbl.push_back(row(1, 1, a[2], 0, 0));
    tbl.push_back(row(1, 0, '0,   0, 0));
    t2_lo = tbl.size();
    tbl.push_back(row(1, 0, '0,    1, 0));
    tbl.push_back(row(1, 1, p0[0], 1, 0));
    tbl.push_back(row(1, 1, p0[1], 0, 0));
    tbl.push_back(row(1, 0, '0,    0, 1));
    tbl.push_back(row(1, 1, q0[0], 0, 1));
    tbl.push_back(row(1, 1, q0[1], 0, 0));
    tbl.push_back(row(1, 0, '0,    1, 0));
    tbl.push_back(row(1, 1, p1[0], 1, 0));
    tbl.push_back(row(1, 1, p1[1], 0, 0));
    tbl.push_back(row(1, 0, '0,    0, 1));
    tbl.push_back(row(1, 1, q1[0], 0, 1));
    tbl.push_back(row(1, 1, q1[1], 0, 0));
    tbl.push_back(row(1, 0, '0,    0, 0));
    t4_lo = tbl.size();
    tbl.push_back(row(1, 0, '0,   1, 0));
    tbl.push_back(row(1, 1, c[0], 1, 0));
    tbl.push_back(row(0, 1, c[1], 0, 0));
    tbl.push_back(row(0, 1, c[1], 0, 0));
    tbl.push_back(row(1, 1, c[1], 1, 0));
    tbl.push_back(row(1, 1, c[2], 1, 0));
    tbl.push_back(row(1, 1, c[3], 0, 0));
    tbl.push_back(row(1, 0, '0,   0, 0));
    t_end = tbl.size();

    do_reset();
    for (int b = 0; b < 3; b++) push0(a[b]);
    user_reset = 1'b0;
    run_rows(t1_lo, t2_lo, "t1");

    do_reset();
    push0(p0[0]); push0(p0[1]); push0(p1[0]); push0(p1[1]);
    push1(q0[0]); push1(q0[1]); push1(q1[0]); push1(q1[1]);
    user_reset = 1'b0;
    run_rows(t2_lo, t4_lo, "t2");

    do_reset();
    push0(f[0]); push0(f[1]);
    push1(g[0]); push1(g[1]);
    user_reset = 1'b0;
    got.delete();
    for (int k = 0; k < 20 && !empty0; k++) tick(1);
    saw_rd1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      saw_rd1 |= rd_en1;
    end
    chk("t3_no_src1_pop", saw_rd1, 0);
    chk("t3_beats_before_refill", got.size(), 2);
    push0(f[2]); push0(f[3]);
    drain(6, 40, 0);
    exp_q = '{f[0], f[1], f[2], f[3], g[0], g[1]};
    cmp_got("t3");

    do_reset();
    for (int b = 0; b < 4; b++) push0(c[b]);
    user_reset = 1'b0;
    run_rows(t4_lo, t_end, "t4");

    for (int b = 0; b < 4; b++) push0(d[b]);
    tick(1);
    tick(1);
    tick(1);
    chk("t5_beat2_valid", m_axis_tvalid, 1);
    chk("t5_beat2", out_ent, d[1]);
    push1(e0);
    user_reset = 1'b1;
    #1;
    chk("t5_async_tvalid", m_axis_tvalid, 0);
    chk("t5_async_fields", out_ent, 0);
    chk("t5_async_rd_en", {rd_en1, rd_en0}, 0);
    tick(1);
    tick(1);
    user_reset = 1'b0;
    got.delete();
    drain(3, 30, 0);
    exp_q = '{d[2], d[3], e0};
    cmp_got("t5");

    do_reset();
    s0q.delete(); s1q.delete();
    for (int s = 0; s < 2; s++) begin
      int np;
      np = $urandom_range(4, 8);
      for (int p = 0; p < np; p++) begin
        int len;
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          logic [80:0] ent;
          ent = {(b == len - 1) ? (8'($urandom) | 8'h01) : 8'hFF,
                 $urandom(), $urandom(), 8'($urandom), b == len - 1};
          if (s == 0) begin push0(ent); s0q.push_back(ent); end
          else begin push1(ent); s1q.push_back(ent); end
        end
      end
    end
    begin
      int i0, i1;
      bit turn, done;
      i0 = 0; i1 = 0; turn = 0;
      exp_q.delete();
      while (i0 < s0q.size() || i1 < s1q.size()) begin
        if (!turn && i0 >= s0q.size()) turn = 1;
        else if (turn && i1 >= s1q.size()) turn = 0;
        done = 0;
        while (!done) begin
          if (!turn) begin exp_q.push_back(s0q[i0]); done = s0q[i0][0]; i0++; end
          else begin exp_q.push_back(s1q[i1]); done = s1q[i1][0]; i1++; end
        end
        turn = !turn;
      end
    end
    user_reset = 1'b0;
    got.delete();
    drain(exp_q.size(), 5000, 1);
    cmp_got("rand");

`ifdef TLPTAP_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 5; p++) push0(mk(0, 7, p, 1, 8'hFF));
    for (int p = 0; p < 3; p++) push1(mk(1, 7, p, 1, 8'hFF));
    user_reset = 1'b0;
    got.delete();
    drain(8, 60, 0);
    chk("stats_beats", got.size(), 8);
    chk("pkt_cnt0_wrap", pkt_cnt0, 5 % (1 << 2));
    chk("pkt_cnt1", pkt_cnt1, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
